// File: rtl/reg_file_ba_sb_pkg.sv
// Shared datapath constants for the general-purpose register file.
package reg_file_ba_sb_pkg;

   localparam int unsigned RF_WIDTH_DEF    = 32;
   localparam int unsigned RF_NUM_REGS_DEF = 16;
   localparam int unsigned RF_R0_IDX       = 0;

endpackage : reg_file_ba_sb_pkg

// File: rtl/reg_file_ba_sb_rf_scoreboard.sv
// Per-register busy scoreboard: set on multicycle issue, cleared when the result is written.
module rf_scoreboard
   import reg_file_ba_sb_pkg::*;
#(
   parameter  int unsigned NUM_REGS = RF_NUM_REGS_DEF,
   localparam int unsigned AW       = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                sb_set,
   input  logic [AW-1:0]       sb_set_addr,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   output logic [NUM_REGS-1:0] busy_vec
);

   logic [NUM_REGS-1:0] busy_d;
   logic [NUM_REGS-1:0] busy_q;

   // Issue of a new op outranks retirement of the previous one on the same register.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         if (sb_set && (sb_set_addr == AW'(i))) begin
            busy_d[i] = 1'b1;
         end else if (wr_en && (wr_addr == AW'(i))) begin
            busy_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_vec = busy_q;

endmodule : rf_scoreboard

// File: rtl/reg_file_ba_sb.sv
// Two-read/one-write register file with optional write bypass, R0 base-address zeroing
// on port A, and a busy scoreboard for multicycle results.
module reg_file_ba_sb
   import reg_file_ba_sb_pkg::*;
#(
   parameter  int unsigned WIDTH    = RF_WIDTH_DEF,
   parameter  int unsigned NUM_REGS = RF_NUM_REGS_DEF,
   parameter  int unsigned BYPASS   = 1,
   localparam int unsigned AW       = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [WIDTH-1:0]    wr_data,
   input  logic [AW-1:0]       rd_addr_a,
   output logic [WIDTH-1:0]    rd_data_a,
   input  logic                ba_out,
   input  logic [AW-1:0]       rd_addr_b,
   output logic [WIDTH-1:0]    rd_data_b,
   input  logic                sb_set,
   input  logic [AW-1:0]       sb_set_addr,
   output logic                busy_a,
   output logic                busy_b,
   output logic [NUM_REGS-1:0] busy_vec
);

   logic [WIDTH-1:0] mem_d [NUM_REGS];
   logic [WIDTH-1:0] mem_q [NUM_REGS];

   logic             hit_a, hit_b;
   logic [WIDTH-1:0] mem_rd_a, mem_rd_b;
   logic             sb_rd_a, sb_rd_b;
   logic             byp_a, byp_b;
   logic             zero_a;

   rf_scoreboard #(
      .NUM_REGS (NUM_REGS)
   ) u_sb (
      .clk         (clk),
      .clr         (clr),
      .sb_set      (sb_set),
      .sb_set_addr (sb_set_addr),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .busy_vec    (busy_vec)
   );

   // Indices past NUM_REGS match no entry, so such writes simply drop.
   always_comb begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         mem_d[i] = mem_q[i];
         if (wr_en && (wr_addr == AW'(i))) begin
            mem_d[i] = wr_data;
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // Read muxes; an unmatched index leaves data and busy at zero.
   always_comb begin
      hit_a    = 1'b0;
      hit_b    = 1'b0;
      mem_rd_a = '0;
      mem_rd_b = '0;
      sb_rd_a  = 1'b0;
      sb_rd_b  = 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         if (rd_addr_a == AW'(i)) begin
            hit_a    = 1'b1;
            mem_rd_a = mem_q[i];
            sb_rd_a  = busy_vec[i];
         end
         if (rd_addr_b == AW'(i)) begin
            hit_b    = 1'b1;
            mem_rd_b = mem_q[i];
            sb_rd_b  = busy_vec[i];
         end
      end
   end

   always_comb begin
      byp_a  = (BYPASS != 0) && wr_en && hit_a && (wr_addr == rd_addr_a);
      byp_b  = (BYPASS != 0) && wr_en && hit_b && (wr_addr == rd_addr_b);
      zero_a = ba_out && (rd_addr_a == AW'(RF_R0_IDX));

      rd_data_a = byp_a ? wr_data : mem_rd_a;
      busy_a    = sb_rd_a;
      // Base-address form zeroes R0 on port A, above any forwarding.
      if (zero_a) begin
         rd_data_a = '0;
         busy_a    = 1'b0;
      end

      rd_data_b = byp_b ? wr_data : mem_rd_b;
      busy_b    = sb_rd_b;
   end

endmodule : reg_file_ba_sb

// File: tb/tb_reg_file_ba_sb.sv
// Bench for reg_file_ba_sb: three configurations share one stimulus stream and are
// each checked against a simple array model of the register file.
module tb_reg_file_ba_sb;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [3:0]  rd_addr_a = '0;
   logic [3:0]  rd_addr_b = '0;
   logic        ba_out = 1'b0;
   logic        sb_set = 1'b0;
   logic [3:0]  sb_set_addr = '0;

   logic [31:0] rda [3];
   logic [31:0] rdb [3];
   logic        bsa [3];
   logic        bsb [3];
   logic [15:0] bv0, bv1;
   logic [11:0] bv2;

   logic [31:0] m_mem [3][16];
   logic        m_bsy [3][16];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   reg_file_ba_sb #(.WIDTH(32), .NUM_REGS(16), .BYPASS(1)) dut0 (
      .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_data_a(rda[0]), .ba_out(ba_out),
      .rd_addr_b(rd_addr_b), .rd_data_b(rdb[0]), .sb_set(sb_set),
      .sb_set_addr(sb_set_addr), .busy_a(bsa[0]), .busy_b(bsb[0]), .busy_vec(bv0));

   reg_file_ba_sb #(.WIDTH(32), .NUM_REGS(16), .BYPASS(0)) dut1 (
      .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_data_a(rda[1]), .ba_out(ba_out),
      .rd_addr_b(rd_addr_b), .rd_data_b(rdb[1]), .sb_set(sb_set),
      .sb_set_addr(sb_set_addr), .busy_a(bsa[1]), .busy_b(bsb[1]), .busy_vec(bv1));

   reg_file_ba_sb #(.WIDTH(32), .NUM_REGS(12), .BYPASS(1)) dut2 (
      .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_data_a(rda[2]), .ba_out(ba_out),
      .rd_addr_b(rd_addr_b), .rd_data_b(rdb[2]), .sb_set(sb_set),
      .sb_set_addr(sb_set_addr), .busy_a(bsa[2]), .busy_b(bsb[2]), .busy_vec(bv2));

   function automatic int cfg_n(input int c);
      return (c == 2) ? 12 : 16;
   endfunction

   function automatic bit cfg_byp(input int c);
      return c != 1;
   endfunction

   function automatic logic [15:0] dut_bv(input int c);
      if (c == 0) return bv0;
      if (c == 1) return bv1;
      return 16'(bv2);
   endfunction

   function automatic logic [31:0] exp_data(input int c, input int addr, input bit port_a);
      if (port_a && ba_out && addr == 0) return 32'h0;
      if (addr >= cfg_n(c)) return 32'h0;
      if (cfg_byp(c) && wr_en && int'(wr_addr) == addr) return wr_data;
      return m_mem[c][addr];
   endfunction

   function automatic logic exp_busy(input int c, input int addr, input bit port_a);
      if (port_a && ba_out && addr == 0) return 1'b0;
      if (addr >= cfg_n(c)) return 1'b0;
      return m_bsy[c][addr];
   endfunction

   function automatic logic [15:0] exp_vec(input int c);
      logic [15:0] v = '0;
      for (int i = 0; i < cfg_n(c); i++) v[i] = m_bsy[c][i];
      return v;
   endfunction

   task automatic model_clear();
      for (int c = 0; c < 3; c++)
         for (int i = 0; i < 16; i++) begin
            m_mem[c][i] = '0;
            m_bsy[c][i] = 1'b0;
         end
   endtask

   // Result arrival clears busy first, then a fresh issue sets it, so issue wins a tie.
   task automatic model_edge();
      if (clr) begin
         model_clear();
         return;
      end
      for (int c = 0; c < 3; c++) begin
         if (wr_en && int'(wr_addr) < cfg_n(c)) begin
            m_mem[c][wr_addr] = wr_data;
            m_bsy[c][wr_addr] = 1'b0;
         end
         if (sb_set && int'(sb_set_addr) < cfg_n(c)) m_bsy[c][sb_set_addr] = 1'b1;
      end
   endtask

   task automatic chk(input string tag, input int c, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s dut%0d cycle %0d: observed %h expected %h", tag, c, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int c = 0; c < 3; c++) begin
         chk("rd_data_a", c, rda[c], exp_data(c, int'(rd_addr_a), 1'b1));
         chk("rd_data_b", c, rdb[c], exp_data(c, int'(rd_addr_b), 1'b0));
         chk("busy_a", c, 32'(bsa[c]), 32'(exp_busy(c, int'(rd_addr_a), 1'b1)));
         chk("busy_b", c, 32'(bsb[c]), 32'(exp_busy(c, int'(rd_addr_b), 1'b0)));
         chk("busy_vec", c, 32'(dut_bv(c)), 32'(exp_vec(c)));
      end
   endtask

   // Inputs change only at the falling edge; check just after, then commit at the rising edge.
   task automatic cycle();
      #1;
      check_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle();
      wr_en = 1'b0;
      sb_set = 1'b0;
      ba_out = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      wr_en = 1'b1;
      wr_addr = a;
      wr_data = d;
   endtask

   task automatic sb(input logic [3:0] a);
      sb_set = 1'b1;
      sb_set_addr = a;
   endtask

   initial begin
      model_clear();
      @(negedge clk);
      cycle();
      rd_addr_a = 4'd5; rd_addr_b = 4'd9;
      cycle();
      clr = 1'b0;

      // Clear mid-stream after writing R3
      wr(4'd3, 32'hDEADBEEF); sb(4'd4); rd_addr_a = 4'd3; rd_addr_b = 4'd4;
      cycle();
      idle(); rd_addr_a = 4'd3; rd_addr_b = 4'd4;
      cycle();
      clr = 1'b1; model_clear();
      cycle();
      clr = 1'b0;
      cycle();

      // R0 base-address zeroing
      wr(4'd0, 32'h0000_1234);
      cycle();
      idle(); ba_out = 1'b1; rd_addr_a = 4'd0; rd_addr_b = 4'd0;
      cycle();
      ba_out = 1'b0;
      cycle();
      ba_out = 1'b1; wr(4'd0, 32'h0000_9999);
      cycle();
      idle();

      // Same-cycle forwarding vs. registered read
      wr(4'd5, 32'h1111_1111);
      cycle();
      wr(4'd5, 32'hA5A5_A5A5); rd_addr_b = 4'd5; rd_addr_a = 4'd5;
      cycle();
      idle();
      cycle();

      // Busy through idle cycles, then cleared by the result write
      sb(4'd7);
      cycle();
      idle(); rd_addr_a = 4'd7; rd_addr_b = 4'd3;
      repeat (3) cycle();
      wr(4'd7, 32'h0000_0077);
      cycle();
      idle();
      cycle();

      // Set and clear on the same register and edge
      sb(4'd2); wr(4'd2, 32'h0000_0055);
      cycle();
      idle(); rd_addr_a = 4'd2; rd_addr_b = 4'd2;
      cycle();

      // Out-of-range index on the 12-entry instance
      wr(4'd1, 32'h0000_0101);
      cycle();
      wr(4'd5, 32'h0000_0505);
      cycle();
      wr(4'd13, 32'h0000_FFFF); sb(4'd13); rd_addr_a = 4'd13; rd_addr_b = 4'd5;
      cycle();
      idle();
      cycle();
      rd_addr_a = 4'd1; rd_addr_b = 4'd13;
      cycle();

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         wr_en       = 1'($urandom_range(0, 1));
         wr_addr     = 4'($urandom_range(0, 15));
         wr_data     = $urandom;
         sb_set      = ($urandom_range(0, 3) == 0);
         sb_set_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
         rd_addr_a   = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
         rd_addr_b   = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
         ba_out      = 1'($urandom_range(0, 1));
         if (clr) begin
            clr = 1'b0;
         end else if ($urandom_range(0, 49) == 0) begin
            clr = 1'b1;
            model_clear();
         end
         cycle();
      end
      idle();
      clr = 1'b0;
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_reg_file_ba_sb
